// File: rtl/tx_pkg.sv
// tx_pkg: parity-mode constants and FSM state encoding shared by the serial transmitter
package tx_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: counts consecutive high button samples while idle and armed, emits a one-cycle trigger
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao,
  input  logic idle,
  output logic trig
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  // trigger on the sample that completes the run; a release re-arms, a trigger disarms
  always_comb begin
    trig    = idle && armed_q && botao && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    armed_d = !botao ? 1'b1 : (trig ? 1'b0 : armed_q);
    cnt_d   = (!botao || !idle || trig) ? '0 : (armed_q ? cnt_q + 1'b1 : cnt_q);
  end
  // register armed flag and run counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end
endmodule

// File: rtl/tx_serial_param.sv
// tx_serial_param: parametrised LSB-first serial frame transmitter triggered by handshake or button
module tx_serial_param
  import tx_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int CLKS_PER_BIT    = 4,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              botao,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              out
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NW = $clog2(DATA_W + 1);

  if (PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("tx_serial_param: PARITY_MODE must be 0..2 and STOP_BITS 1..2");
  end

  tx_state_t         state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [NW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              par_q, par_d;
  logic              out_q, out_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              trig, wrap, accept, last_data, last_stop;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clock   (clock),
    .reset_n (reset_n),
    .botao   (botao),
    .idle    (state_q == IDLE),
    .trig    (trig)
  );

  // next-state, shift and bit-timing logic; outputs derive from the next state so they register cleanly
  always_comb begin
    wrap      = baud_q == BW'(CLKS_PER_BIT - 1);
    accept    = (state_q == IDLE) && ((start && ready_q) || trig);
    last_data = bit_q == NW'(DATA_W - 1);
    last_stop = (STOP_BITS == 1) || (bit_q == NW'(1));
    baud_d    = (state_q == IDLE || wrap) ? '0 : baud_q + 1'b1;
    state_d   = state_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_d     = par_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        sh_d    = data;
        par_d   = (^data) ^ (PARITY_MODE == PAR_ODD);
      end
      START: if (wrap) state_d = DATA;
      DATA: if (wrap) begin
        sh_d    = sh_q >> 1;
        bit_d   = last_data ? '0 : bit_q + 1'b1;
        state_d = !last_data ? DATA : (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
      end
      PARITY: if (wrap) state_d = STOP;
      STOP: if (wrap) begin
        bit_d   = last_stop ? '0 : bit_q + 1'b1;
        state_d = last_stop ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    out_d   = (state_d == START)  ? 1'b0 :
              (state_d == DATA)   ? sh_d[0] :
              (state_d == PARITY) ? par_d : 1'b1;
    ready_d = state_d == IDLE;
    busy_d  = state_d != IDLE;
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  // state and registered outputs; reset aborts any frame and idles the line high
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_tx_serial_param.sv
// tb_tx_serial_param: scoreboard bench driving two transmitter configurations from shared stimulus
module tb_tx_serial_param;
  localparam int CPB = 4;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       botao = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] ready_w, busy_w, done_w, out_w;

  int checks = 0;
  int errors = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int pm[2] = '{1, 2};
  int sb[2] = '{1, 2};
  int rem[2] = '{0, 0};
  int armed[2] = '{0, 0};
  int cnt[2] = '{0, 0};
  int in_frame[2] = '{0, 0};
  int pend_done[2] = '{0, 0};

  always #5 clk = ~clk;

  tx_serial_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .DEBOUNCE_CYCLES(DEB)) dut0 (
    .clock(clk), .reset_n(reset_n), .botao(botao), .start(start), .data(data),
    .ready(ready_w[0]), .busy(busy_w[0]), .done(done_w[0]), .out(out_w[0]));

  tx_serial_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2), .DEBOUNCE_CYCLES(DEB)) dut1 (
    .clock(clk), .reset_n(reset_n), .botao(botao), .start(start), .data(data),
    .ready(ready_w[1]), .busy(busy_w[1]), .done(done_w[1]), .out(out_w[1]));

  function automatic int frame_len(input int w);
    return (1 + 8 + ((pm[w] != 0) ? 1 : 0) + sb[w]) * CPB;
  endfunction

  // expected line level for every clock of the frame, cycle 0 = first clock after acceptance
  function automatic logic [63:0] wave(input int w, input logic [7:0] d);
    logic [15:0] slots;
    logic [63:0] r;
    slots = '1;
    slots[0] = 1'b0;
    for (int i = 0; i < 8; i++) slots[i+1] = d[i];
    if (pm[w] != 0) slots[9] = (pm[w] == 2) ? ~(^d) : ^d;
    r = '0;
    for (int c = 0; c < frame_len(w); c++) r[c] = slots[c / CPB];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural reference: busy-time countdown plus press tracking, sampled at each edge
  task automatic model_step(input int w);
    bit idle;
    bit trig;
    idle = rem[w] == 0;
    trig = 1'b0;
    if (!reset_n) begin
      rem[w] = 0; armed[w] = 0; cnt[w] = 0;
      if (w == 0) q0.delete(); else q1.delete();
      return;
    end
    if (!botao) begin
      armed[w] = 1; cnt[w] = 0;
    end else if (!idle) begin
      cnt[w] = 0;
    end else if (armed[w] != 0) begin
      cnt[w]++;
      if (cnt[w] == DEB) begin trig = 1'b1; armed[w] = 0; cnt[w] = 0; end
    end
    if (!idle) rem[w]--;
    else if (start || trig) begin
      rem[w] = frame_len(w);
      if (w == 0) q0.push_back(wave(0, data)); else q1.push_back(wave(1, data));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  task automatic monitor(input int w);
    logic [63:0] exp_w, act;
    int cyc;
    bit bad;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        in_frame[w] = 0; pend_done[w] = 0;
        continue;
      end
      if (pend_done[w] != 0) begin
        check($sformatf("done_cycle dut%0d {done,ready,busy}", w),
              64'({done_w[w], ready_w[w], busy_w[w]}), 64'(3'b110));
        pend_done[w] = 0;
      end else if (in_frame[w] == 0) begin
        check($sformatf("idle_done dut%0d", w), 64'(done_w[w]), 64'(0));
      end
      if (in_frame[w] == 0 && busy_w[w]) begin
        in_frame[w] = 1; cyc = 0; act = '0; bad = 1'b0;
        if ((w == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          checks++; errors++;
          $display("FAIL unexpected_frame dut%0d: frame started, 0 expected frames queued", w);
          exp_w = '0;
        end else exp_w = (w == 0) ? q0.pop_front() : q1.pop_front();
      end
      if (in_frame[w] != 0) begin
        act[cyc] = out_w[w];
        if (ready_w[w] || !busy_w[w] || done_w[w]) bad = 1'b1;
        cyc++;
        if (cyc == frame_len(w)) begin
          in_frame[w] = 0; pend_done[w] = 1;
          check($sformatf("frame_wave dut%0d", w), act, exp_w);
          check($sformatf("frame_ctl dut%0d", w), 64'(bad), 64'(0));
        end
      end
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
  join_none

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; data = d;
    @(negedge clk);
    start = 1'b0; data = 8'($urandom);
  endtask

  task automatic check_idle_after_reset(input string name);
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++)
      check($sformatf("%s dut%0d {out,ready,busy,done}", name, w),
            64'({out_w[w], ready_w[w], busy_w[w], done_w[w]}), 64'(4'b1100));
  endtask

  initial begin
    int i;
    tick(3);
    check_idle_after_reset("reset");
    @(negedge clk); reset_n = 1'b1;
    send(8'hA5); tick(60);
    send(8'h01); tick(60);
    data = 8'h5A;
    botao = 1'b1; tick(2); botao = 1'b0; tick(5);
    botao = 1'b1; tick(200); botao = 1'b0; tick(5);
    data = 8'h77;
    botao = 1'b1; tick(3); botao = 1'b0; tick(60);
    botao = 1'b1; tick(2);
    start = 1'b1; data = 8'h3C; tick(1);
    start = 1'b0; data = 8'hFF; tick(100);
    botao = 1'b0; tick(5);
    send(8'h96); tick(16);
    reset_n = 1'b0;
    check_idle_after_reset("mid_frame_reset");
    @(negedge clk); reset_n = 1'b1;
    send(8'hC3); tick(60);
    start = 1'b1; data = 8'($urandom);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) data = 8'($urandom);
    end
    start = 1'b0; tick(60);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = ($urandom_range(24) == 0);
      data = 8'($urandom);
      if ($urandom_range(9) == 0) botao = ~botao;
    end
    start = 1'b0; botao = 1'b0;
    for (i = 0; i < 300; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && in_frame[0] == 0 && in_frame[1] == 0 &&
          pend_done[0] == 0 && pend_done[1] == 0 && rem[0] == 0 && rem[1] == 0) break;
      @(negedge clk);
    end
    check("drain_outstanding", 64'(q0.size() + q1.size() + in_frame[0] + in_frame[1] + pend_done[0] + pend_done[1]), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
